// File: rtl/mips_defs_pkg.sv
// Shared MIPS decode constants and exception codes for the pipeline stage registers
// and the exception classifier.
package mips_defs;

   localparam int DEF_EXC_W = 5;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_LB   = 6'h20;
   localparam logic [5:0] OP_LH   = 6'h21;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_LBU  = 6'h24;
   localparam logic [5:0] OP_LHU  = 6'h25;
   localparam logic [5:0] OP_SB   = 6'h28;
   localparam logic [5:0] OP_SH   = 6'h29;
   localparam logic [5:0] OP_SW   = 6'h2B;

   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_SUB  = 6'h22;

   localparam int EXC_NONE = 0;
   localparam int EXC_ADEL = 4;
   localparam int EXC_ADES = 5;
   localparam int EXC_RI   = 10;
   localparam int EXC_OV   = 12;

   function automatic logic is_load(input logic [5:0] op);
      return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU) ||
             (op == OP_LH) || (op == OP_LHU);
   endfunction

   function automatic logic is_store(input logic [5:0] op);
      return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
   endfunction

endpackage

// File: rtl/exc_classify.sv
// Maps an overflow/address-error pulse to the exception code implied by the
// instruction; trapping add/sub/addi only, so addu/addiu never raise.
module exc_classify
   import mips_defs::*;
#(
   parameter int EXC_W = DEF_EXC_W
) (
   input  logic [31:0]      ir,
   input  logic             ovf,
   output logic [EXC_W-1:0] local_code
);

   logic [5:0] op;
   logic [5:0] fn;

   assign op = ir[31:26];
   assign fn = ir[5:0];

   always_comb begin
      local_code = EXC_W'(EXC_NONE);
      if (ovf) begin
         if (is_load(op)) begin
            local_code = EXC_W'(EXC_ADEL);
         end else if (is_store(op)) begin
            local_code = EXC_W'(EXC_ADES);
         end else if ((op == OP_R && (fn == FN_ADD || fn == FN_SUB)) || op == OP_ADDI) begin
            local_code = EXC_W'(EXC_OV);
         end
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register: IR, PC, payload words, delay-slot flag and a
// first-wins exception code merged with the stage's own overflow/address error.
module pipe_stage_reg
   import mips_defs::*;
#(
   parameter int NWORDS    = 6,
   parameter int EXC_W     = DEF_EXC_W,
   parameter bit LOCAL_EXC = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  bubble,
   input  logic                  flush,
   input  logic [31:0]           ir_d,
   input  logic [31:0]           pc_d,
   input  logic                  bd_d,
   input  logic [EXC_W-1:0]      exc_d,
   input  logic [32*NWORDS-1:0]  payload_d,
   input  logic                  ovf_i,
   output logic [31:0]           ir_q,
   output logic [31:0]           pc_q,
   output logic                  bd_q,
   output logic                  valid_q,
   output logic [32*NWORDS-1:0]  payload_q,
   output logic [EXC_W-1:0]      exc_q
);

   logic [EXC_W-1:0] exc_r;
   logic [EXC_W-1:0] local_code;

   // Control priority each edge: reset > flush > bubble > hold (en=0) > load.
   // A bubble keeps pc/bd so an interrupt taken on it still reports EPC and BD.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         ir_q    <= '0;
         pc_q    <= '0;
         bd_q    <= 1'b0;
         valid_q <= 1'b0;
         exc_r   <= '0;
      end else if (bubble) begin
         ir_q    <= '0;
         pc_q    <= pc_d;
         bd_q    <= bd_d;
         valid_q <= 1'b0;
         exc_r   <= '0;
      end else if (en) begin
         ir_q    <= ir_d;
         pc_q    <= pc_d;
         bd_q    <= bd_d;
         valid_q <= 1'b1;
         exc_r   <= exc_d;
      end
   end

   for (genvar k = 0; k < NWORDS; k++) begin : g_word
      logic [31:0] word_r;

      always_ff @(posedge clk) begin
         if (reset || flush || bubble) begin
            word_r <= '0;
         end else if (en) begin
            word_r <= payload_d[32*k +: 32];
         end
      end

      assign payload_q[32*k +: 32] = word_r;
   end

   exc_classify #(.EXC_W(EXC_W)) u_classify (
      .ir         (ir_q),
      .ovf        (ovf_i),
      .local_code (local_code)
   );

   // An upstream code always wins; bubbles and flushed slots never trap locally.
   always_comb begin
      exc_q = '0;
      if (exc_r != '0) begin
         exc_q = exc_r;
      end else if (LOCAL_EXC && valid_q) begin
         exc_q = local_code;
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: default build plus NWORDS=1 (pass-through) and NWORDS=16 builds.
module tb_pipe_stage_reg;

   localparam int VW = 32 + 32 + 1 + 1 + 5 + 32;

   logic          clk;
   logic          reset;
   logic          en;
   logic          bubble;
   logic          flush;
   logic [31:0]   ir_d;
   logic [31:0]   pc_d;
   logic          bd_d;
   logic [4:0]    exc_d;
   logic [191:0]  payload_d;
   logic [31:0]   payload1_d;
   logic [511:0]  payload16_d;
   logic          ovf_i;

   logic [31:0]   ir_q, pc_q;
   logic          bd_q, valid_q;
   logic [191:0]  payload_q;
   logic [4:0]    exc_q;

   logic [31:0]   ir1_q, pc1_q;
   logic          bd1_q, valid1_q;
   logic [31:0]   payload1_q;
   logic [4:0]    exc1_q;

   logic [31:0]   ir16_q, pc16_q;
   logic          bd16_q, valid16_q;
   logic [511:0]  payload16_q;
   logic [4:0]    exc16_q;

   logic [VW-1:0] obs;
   logic [VW-1:0] exp_q[$];
   int            checks;
   int            errors;

   assign obs = {ir_q, pc_q, bd_q, valid_q, exc_q, payload_q[31:0]};

   pipe_stage_reg #(.NWORDS(6), .EXC_W(5), .LOCAL_EXC(1'b1)) dut (
      .clk(clk), .reset(reset), .en(en), .bubble(bubble), .flush(flush),
      .ir_d(ir_d), .pc_d(pc_d), .bd_d(bd_d), .exc_d(exc_d), .payload_d(payload_d),
      .ovf_i(ovf_i), .ir_q(ir_q), .pc_q(pc_q), .bd_q(bd_q), .valid_q(valid_q),
      .payload_q(payload_q), .exc_q(exc_q)
   );

   pipe_stage_reg #(.NWORDS(1), .EXC_W(5), .LOCAL_EXC(1'b0)) dut_n1 (
      .clk(clk), .reset(reset), .en(en), .bubble(bubble), .flush(flush),
      .ir_d(ir_d), .pc_d(pc_d), .bd_d(bd_d), .exc_d(exc_d), .payload_d(payload1_d),
      .ovf_i(ovf_i), .ir_q(ir1_q), .pc_q(pc1_q), .bd_q(bd1_q), .valid_q(valid1_q),
      .payload_q(payload1_q), .exc_q(exc1_q)
   );

   pipe_stage_reg #(.NWORDS(16), .EXC_W(5), .LOCAL_EXC(1'b1)) dut_n16 (
      .clk(clk), .reset(reset), .en(en), .bubble(bubble), .flush(flush),
      .ir_d(ir_d), .pc_d(pc_d), .bd_d(bd_d), .exc_d(exc_d), .payload_d(payload16_d),
      .ovf_i(ovf_i), .ir_q(ir16_q), .pc_q(pc16_q), .bd_q(bd16_q), .valid_q(valid16_q),
      .payload_q(payload16_q), .exc_q(exc16_q)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [VW-1:0] pack(input logic [31:0] ir, input logic [31:0] pc,
                                          input logic bd, input logic v,
                                          input logic [4:0] e, input logic [31:0] w0);
      return {ir, pc, bd, v, e, w0};
   endfunction

   task automatic test_reset();
      logic [VW-1:0] exp_v;
      reset = 1'b1; en = 1'b1; bubble = 1'b0; flush = 1'b0;
      ir_d = 32'h00851020; pc_d = 32'h1234; bd_d = 1'b1; exc_d = 5'd3; ovf_i = 1'b0;
      payload_d = '1; payload1_d = '1; payload16_d = '1;
      tick();
      reset = 1'b0; en = 1'b0;
      exp_q.push_back('0);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL reset got %h exp %h", obs, exp_v);
      end
      checks++;
      if ({ir16_q, pc16_q, bd16_q, valid16_q, exc16_q, payload16_q} !== '0) begin
         errors++;
         $display("FAIL reset_n16 got valid %b payload %h exp 0", valid16_q, payload16_q);
      end
   endtask

   task automatic test_load_hold();
      logic [VW-1:0]  exp_v;
      logic [191:0]   saved;
      en = 1'b1; ir_d = 32'h00851020; pc_d = 32'h3000; bd_d = 1'b0; exc_d = 5'd0;
      payload_d[31:0] = 32'h12345678;
      for (int k = 1; k < 6; k++) payload_d[32*k +: 32] = 32'hA000_0000 + k;
      saved = payload_d;
      tick();
      en = 1'b0;
      exp_q.push_back(pack(32'h00851020, 32'h3000, 1'b0, 1'b1, 5'd0, 32'h12345678));
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL load got %h exp %h", obs, exp_v);
      end
      for (int i = 0; i < 3; i++) begin
         ir_d = $urandom; pc_d = $urandom; bd_d = 1'b1; exc_d = 5'd9;
         for (int k = 0; k < 6; k++) payload_d[32*k +: 32] = $urandom;
         tick();
         exp_q.push_back(pack(32'h00851020, 32'h3000, 1'b0, 1'b1, 5'd0, 32'h12345678));
         exp_v = exp_q.pop_front();
         checks++;
         if (obs !== exp_v || payload_q !== saved) begin
            errors++;
            $display("FAIL hold%0d got %h payload %h exp %h payload %h", i, obs, payload_q, exp_v, saved);
         end
      end
      exc_d = 5'd0; bd_d = 1'b0;
   endtask

   task automatic test_local_ovf();
      logic [VW-1:0] exp_v;
      logic [31:0]   ir_tab[6];
      logic [4:0]    code_tab[6];
      ir_tab   = '{32'h20A5FFFF, 32'h00851021, 32'h8C820000, 32'hA0820000, 32'h00851022, 32'h24A5FFFF};
      code_tab = '{5'd12, 5'd0, 5'd4, 5'd5, 5'd12, 5'd0};
      // add still held from the previous test
      ovf_i = 1'b1;
      #1;
      exp_q.push_back(pack(32'h00851020, 32'h3000, 1'b0, 1'b1, 5'd12, 32'h12345678));
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL ovf_add got %h exp %h", obs, exp_v);
      end
      checks++;
      if (exc1_q !== 5'd0) begin
         errors++;
         $display("FAIL ovf_passthru got %0d exp 0", exc1_q);
      end
      ovf_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
         en = 1'b1; ir_d = ir_tab[i]; pc_d = 32'h3004; bd_d = 1'b0; exc_d = 5'd0;
         payload_d = '0; payload_d[31:0] = 32'(i + 1);
         tick();
         en = 1'b0;
         exp_q.push_back(pack(ir_tab[i], 32'h3004, 1'b0, 1'b1, 5'd0, 32'(i + 1)));
         exp_v = exp_q.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL ovf_load%0d got %h exp %h", i, obs, exp_v);
         end
         ovf_i = 1'b1;
         #1;
         exp_q.push_back(pack(ir_tab[i], 32'h3004, 1'b0, 1'b1, code_tab[i], 32'(i + 1)));
         exp_v = exp_q.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL ovf_code%0d got %h exp %h", i, obs, exp_v);
         end
         ovf_i = 1'b0;
      end
   endtask

   task automatic test_upstream();
      logic [VW-1:0] exp_v;
      en = 1'b1; ir_d = 32'h8C820000; pc_d = 32'h3010; bd_d = 1'b0; exc_d = 5'd10;
      payload_d = '0; ovf_i = 1'b0;
      tick();
      en = 1'b0; exc_d = 5'd0;
      for (int i = 0; i < 2; i++) begin
         ovf_i = (i == 1);
         #1;
         exp_q.push_back(pack(32'h8C820000, 32'h3010, 1'b0, 1'b1, 5'd10, 32'd0));
         exp_v = exp_q.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL upstream%0d got %h exp %h", i, obs, exp_v);
         end
      end
      ovf_i = 1'b0;
   endtask

   task automatic test_bubble();
      logic [VW-1:0] exp_v;
      bubble = 1'b1; en = 1'b0; ir_d = 32'h00851020; pc_d = 32'h3008; bd_d = 1'b1;
      exc_d = 5'd7;
      for (int k = 0; k < 6; k++) payload_d[32*k +: 32] = $urandom | 32'h1;
      tick();
      bubble = 1'b0; exc_d = 5'd0;
      for (int i = 0; i < 2; i++) begin
         ovf_i = (i == 1);
         #1;
         exp_q.push_back(pack(32'h0, 32'h3008, 1'b1, 1'b0, 5'd0, 32'd0));
         exp_v = exp_q.pop_front();
         checks++;
         if (obs !== exp_v || payload_q !== '0) begin
            errors++;
            $display("FAIL bubble%0d got %h payload %h exp %h", i, obs, payload_q, exp_v);
         end
      end
      ovf_i = 1'b0; bd_d = 1'b0;
   endtask

   task automatic test_flush();
      logic [VW-1:0] exp_v;
      logic [31:0]   w0;
      en = 1'b1; ir_d = 32'h00851020; pc_d = 32'h300C; bd_d = 1'b1; exc_d = 5'd0;
      for (int k = 0; k < 6; k++) payload_d[32*k +: 32] = $urandom;
      w0 = payload_d[31:0];
      tick();
      exp_q.push_back(pack(32'h00851020, 32'h300C, 1'b1, 1'b1, 5'd0, w0));
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL flush_pre got %h exp %h", obs, exp_v);
      end
      flush = 1'b1; bubble = 1'b1; en = 1'b1; pc_d = 32'h3010; exc_d = 5'd6;
      tick();
      flush = 1'b0; bubble = 1'b0; en = 1'b0; exc_d = 5'd0; bd_d = 1'b0;
      exp_q.push_back('0);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v || payload_q !== '0) begin
         errors++;
         $display("FAIL flush got %h payload %h exp %h", obs, payload_q, exp_v);
      end
   endtask

   task automatic test_reset_stall();
      logic [VW-1:0] exp_v;
      logic [511:0]  saved16;
      en = 1'b1; ir_d = 32'h00851020; pc_d = 32'h3000; bd_d = 1'b0; exc_d = 5'd0;
      payload_d = '0; payload_d[31:0] = 32'h12345678;
      payload1_d = 32'hCAFEF00D;
      for (int k = 0; k < 16; k++) payload16_d[32*k +: 32] = $urandom | 32'h1;
      saved16 = payload16_d;
      tick();
      en = 1'b0;
      tick();
      exp_q.push_back(pack(32'h00851020, 32'h3000, 1'b0, 1'b1, 5'd0, 32'h12345678));
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v || payload16_q !== saved16 || payload1_q !== 32'hCAFEF00D) begin
         errors++;
         $display("FAIL stall got %h n16 %h n1 %h exp %h", obs, payload16_q, payload1_q, exp_v);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_q.push_back('0);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v || payload_q !== '0) begin
         errors++;
         $display("FAIL stall_reset got %h payload %h exp %h", obs, payload_q, exp_v);
      end
      checks++;
      if (payload16_q !== '0 || valid16_q !== 1'b0 || pc16_q !== 32'h0) begin
         errors++;
         $display("FAIL stall_reset_n16 got payload %h valid %b pc %h exp 0", payload16_q, valid16_q, pc16_q);
      end
      checks++;
      if (payload1_q !== 32'h0 || valid1_q !== 1'b0 || ir1_q !== 32'h0 || bd1_q !== 1'b0) begin
         errors++;
         $display("FAIL stall_reset_n1 got payload %h valid %b ir %h exp 0", payload1_q, valid1_q, ir1_q);
      end
   endtask

   task automatic test_back_to_back();
      logic [VW-1:0] exp_v;
      logic [31:0]   m_ir, m_pc, m_w0;
      logic          m_bd, m_valid;
      logic [4:0]    m_exc;
      // starts from the reset state left by the previous test
      m_ir = '0; m_pc = '0; m_w0 = '0; m_bd = 1'b0; m_valid = 1'b0; m_exc = '0;
      ovf_i = 1'b0;
      for (int i = 0; i < 24; i++) begin
         en = (i < 6) ? 1'b1 : 1'($urandom_range(0, 1));
         ir_d = $urandom; pc_d = $urandom; bd_d = 1'($urandom_range(0, 1));
         exc_d = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
         for (int k = 0; k < 6; k++) payload_d[32*k +: 32] = $urandom;
         if (en) begin
            m_ir = ir_d; m_pc = pc_d; m_bd = bd_d; m_valid = 1'b1; m_exc = exc_d;
            m_w0 = payload_d[31:0];
         end
         exp_q.push_back(pack(m_ir, m_pc, m_bd, m_valid, m_exc, m_w0));
         tick();
         exp_v = exp_q.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL b2b%0d got %h exp %h", i, obs, exp_v);
         end
      end
      en = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_load_hold();
      test_local_ovf();
      test_upstream();
      test_bubble();
      test_flush();
      test_reset_stall();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
